// File: rtl/player_pos_uart_tx.sv
// UART transmitter for player position frames: 0xA5 sync byte, click/x/y bytes, idle gap.
// Define TX_CHECKSUM_EN to append an XOR checksum byte (6-byte frame instead of 5).
module player_pos_uart_tx #(
    parameter int CLKS_PER_BIT = 564,
    parameter int GAP_BITS     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        click,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        GAP
    } state_t;

    localparam logic [11:0] CPB_LAST = 12'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
`ifdef TX_CHECKSUM_EN
    localparam logic [2:0]  LAST_BYTE = 3'd5;
`else
    localparam logic [2:0]  LAST_BYTE = 3'd4;
`endif

    state_t      r_state;
    logic [11:0] r_clkCnt;
    logic [2:0]  r_bitIdx;
    logic [2:0]  r_byteIdx;
    logic [3:0]  r_gapCnt;
    logic [24:0] r_capture;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    logic        w_bitEnd;
    logic [2:0]  w_nextBitIdx;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;
    logic [7:0]  w_b4;
    logic [7:0]  w_byte;

    // Capture layout is {click, xpos[11:0], ypos[11:0]}.
    assign w_b1 = {3'b000, r_capture[24], r_capture[23:20]};
    assign w_b2 = r_capture[19:12];
    assign w_b3 = {4'h0, r_capture[11:8]};
    assign w_b4 = r_capture[7:0];

    assign w_bitEnd     = (r_clkCnt == CPB_LAST);
    assign w_nextBitIdx = r_bitIdx + 3'd1;

`ifdef TX_CHECKSUM_EN
    logic [7:0] w_checksum;
    assign w_checksum = w_b1 ^ w_b2 ^ w_b3 ^ w_b4;
`endif

    always_comb begin
        w_byte = 8'hA5;
        case (r_byteIdx)
            3'd1:    w_byte = w_b1;
            3'd2:    w_byte = w_b2;
            3'd3:    w_byte = w_b3;
            3'd4:    w_byte = w_b4;
`ifdef TX_CHECKSUM_EN
            3'd5:    w_byte = w_checksum;
`endif
            default: w_byte = 8'hA5;
        endcase
    end

    // Every state transition loads the next line level into r_tx, so tx never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clkCnt  <= '0;
            r_bitIdx  <= '0;
            r_byteIdx <= '0;
            r_gapCnt  <= '0;
            r_capture <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_capture <= {click, xpos, ypos};
                        r_state   <= START_BIT;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_clkCnt  <= '0;
                        r_bitIdx  <= '0;
                        r_byteIdx <= '0;
                        r_gapCnt  <= '0;
                    end
                end

                START_BIT: begin
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        r_bitIdx <= '0;
                        r_tx     <= w_byte[0];
                        r_state  <= DATA_BITS;
                    end else begin
                        r_clkCnt <= r_clkCnt + 12'd1;
                    end
                end

                DATA_BITS: begin
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_bitIdx <= w_nextBitIdx;
                            r_tx     <= w_byte[w_nextBitIdx];
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 12'd1;
                    end
                end

                STOP_BIT: begin
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        if (r_byteIdx == LAST_BYTE) begin
                            if (GAP_BITS == 0) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_gapCnt <= '0;
                                r_state  <= GAP;
                            end
                        end else begin
                            r_byteIdx <= r_byteIdx + 3'd1;
                            r_tx      <= 1'b0;
                            r_state   <= START_BIT;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 12'd1;
                    end
                end

                GAP: begin
                    r_tx <= 1'b1;
                    if (w_bitEnd) begin
                        r_clkCnt <= '0;
                        if (r_gapCnt == GAP_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_gapCnt <= r_gapCnt + 4'd1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 12'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
